// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and operand-source selection for the operand fetch stage.
// R15 reads as PC + PC_OFFSET and never participates in hazard tracking.
package operand_fetch_stage_pkg;

    localparam int DW_DEFAULT        = 32;
    localparam int RW_DEFAULT        = 4;
    localparam int PC_OFFSET_DEFAULT = 8;
    localparam int NUM_SRC           = 3;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        OPSEL_RDAT = 2'd0,
        OPSEL_WB   = 2'd1,
        OPSEL_PC   = 2'd2
    } opsel_e;

    // PC read beats writeback bypass, which beats the RegFile value.
    function automatic opsel_e opsel(input logic is_pc, input logic wb_hit);
        if (is_pc) begin
            return OPSEL_PC;
        end
        if (wb_hit) begin
            return OPSEL_WB;
        end
        return OPSEL_RDAT;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on writeback, with a combinational query per source operand.
module reg_scoreboard
    import operand_fetch_stage_pkg::*;
#(
    parameter int RW = RW_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         set_en,
    input  logic [RW-1:0]                set_addr,
    input  logic                         clr_en,
    input  logic [RW-1:0]                clr_addr,
    input  logic [NUM_SRC-1:0][RW-1:0]   query_addr,
    output logic [NUM_SRC-1:0]           query_pend
);

    localparam int NREG = 2 ** RW;

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pend_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_query
            assign query_pend[gi] = pend_q[query_addr[gi]];
        end
    endgenerate

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read stage: drives RegFile read addresses, resolves operands with
// PC/writeback bypass, stalls on scoreboard hazards, and holds a valid/ready slot.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = DW_DEFAULT,
    parameter int REGFILE_WIDTH = RW_DEFAULT,
    parameter int PC_OFFSET     = PC_OFFSET_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REGFILE_WIDTH-1:0] in_rn,
    input  logic [REGFILE_WIDTH-1:0] in_rm,
    input  logic [REGFILE_WIDTH-1:0] in_rs,
    input  logic                     in_use_rn,
    input  logic                     in_use_rm,
    input  logic                     in_use_rs,
    input  logic [REGFILE_WIDTH-1:0] in_rd,
    input  logic                     in_rd_we,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    output logic [REGFILE_WIDTH-1:0] RADD1,
    output logic [REGFILE_WIDTH-1:0] RADD2,
    output logic [REGFILE_WIDTH-1:0] RADD3,
    input  logic [DATA_WIDTH-1:0]    RDAT1,
    input  logic [DATA_WIDTH-1:0]    RDAT2,
    input  logic [DATA_WIDTH-1:0]    RDAT3,
    input  logic [REGFILE_WIDTH-1:0] WADD,
    input  logic [DATA_WIDTH-1:0]    WDAT,
    input  logic                     WEN,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_op1,
    output logic [DATA_WIDTH-1:0]    out_op2,
    output logic [DATA_WIDTH-1:0]    out_op3,
    output logic [REGFILE_WIDTH-1:0] out_rd,
    output logic                     out_rd_we
);

    localparam int DW = DATA_WIDTH;
    localparam int RW = REGFILE_WIDTH;
    localparam logic [RW-1:0] PC_REG = RW'(REG_PC);

    logic [NUM_SRC-1:0][RW-1:0] src_addr;
    logic [NUM_SRC-1:0][DW-1:0] src_rdat;
    logic [NUM_SRC-1:0][DW-1:0] src_op;
    logic [NUM_SRC-1:0]         src_use;
    logic [NUM_SRC-1:0]         src_pend;
    logic [NUM_SRC-1:0]         src_haz;
    logic [DW-1:0]              pc_operand;
    logic                       hazard;
    logic                       accept;
    logic                       sb_set;

    logic                       out_valid_q, out_valid_d;
    logic [NUM_SRC-1:0][DW-1:0] op_q, op_d;
    logic [RW-1:0]              rd_q, rd_d;
    logic                       rd_we_q, rd_we_d;

    assign src_addr   = {in_rs, in_rm, in_rn};
    assign src_rdat   = {RDAT3, RDAT2, RDAT1};
    assign src_use    = {in_use_rs, in_use_rm, in_use_rn};
    assign pc_operand = in_pc + DW'(PC_OFFSET);

    assign RADD1 = in_rn;
    assign RADD2 = in_rm;
    assign RADD3 = in_rs;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic   is_pc;
            logic   wb_hit;
            opsel_e sel;
            assign is_pc  = (src_addr[gi] == PC_REG);
            assign wb_hit = WEN && (WADD == src_addr[gi]);
            assign sel    = opsel(is_pc, wb_hit);
            assign src_op[gi] = (sel == OPSEL_PC) ? pc_operand :
                                (sel == OPSEL_WB) ? WDAT : src_rdat[gi];
            // A writeback landing this cycle resolves the hazard through the bypass.
            assign src_haz[gi] = src_use[gi] && !is_pc && src_pend[gi] && !wb_hit;
        end
    endgenerate

    assign hazard   = |src_haz;
    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign sb_set   = accept && in_rd_we && (in_rd != PC_REG);

    reg_scoreboard #(
        .RW(RW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (sb_set),
        .set_addr   (in_rd),
        .clr_en     (WEN),
        .clr_addr   (WADD),
        .query_addr (src_addr),
        .query_pend (src_pend)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        if (accept) begin
            out_valid_d = 1'b1;
            op_d        = src_op;
            rd_d        = in_rd;
            rd_we_d     = in_rd_we;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op1   = op_q[0];
    assign out_op2   = op_q[1];
    assign out_op3   = op_q[2];
    assign out_rd    = rd_q;
    assign out_rd_we = rd_we_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed scoreboard bench for operand_fetch_stage: expected slot contents are
// queued when an instruction is driven and compared when the slot loads.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_rn, in_rm, in_rs, in_rd;
    logic        in_use_rn, in_use_rm, in_use_rs, in_rd_we;
    logic [31:0] in_pc;
    logic [3:0]  RADD1, RADD2, RADD3;
    logic [31:0] RDAT1, RDAT2, RDAT3;
    logic [3:0]  WADD;
    logic [31:0] WDAT;
    logic        WEN;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2, out_op3;
    logic [3:0]  out_rd;
    logic        out_rd_we;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
        logic [3:0]  rd;
        logic        rd_we;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        last_rec;
    logic        exp_valid;
    logic [31:0] rf [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign RDAT1 = rf[RADD1];
    assign RDAT2 = rf[RADD2];
    assign RDAT3 = rf[RADD3];

    operand_fetch_stage dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_rs     (in_rs),
        .in_use_rn (in_use_rn),
        .in_use_rm (in_use_rm),
        .in_use_rs (in_use_rs),
        .in_rd     (in_rd),
        .in_rd_we  (in_rd_we),
        .in_pc     (in_pc),
        .RADD1     (RADD1),
        .RADD2     (RADD2),
        .RADD3     (RADD3),
        .RDAT1     (RDAT1),
        .RDAT2     (RDAT2),
        .RDAT3     (RDAT3),
        .WADD      (WADD),
        .WDAT      (WDAT),
        .WEN       (WEN),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_op3   (out_op3),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference operand resolution from the currently driven inputs.
    function automatic logic [31:0] exp_op(input logic [3:0] s);
        if (s == 4'd15) return in_pc + 32'd8;
        if (WEN && (WADD == s)) return WDAT;
        return rf[s];
    endfunction

    task automatic check_slot(input string tag, input rec_t r);
        check_val({tag, ".op1"}, out_op1, r.op1);
        check_val({tag, ".op2"}, out_op2, r.op2);
        check_val({tag, ".op3"}, out_op3, r.op3);
        check_val({tag, ".rd"}, {28'd0, out_rd}, {28'd0, r.rd});
        check_val({tag, ".rd_we"}, {31'd0, out_rd_we}, {31'd0, r.rd_we});
    endtask

    task automatic drive(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [3:0] rs, input logic [2:0] use_m, input logic [3:0] rd,
                         input logic we, input logic [31:0] pc, input logic wen,
                         input logic [3:0] wadd, input logic [31:0] wdat, input logic ordy);
        in_valid  = v;
        in_rn     = rn;
        in_rm     = rm;
        in_rs     = rs;
        in_use_rn = use_m[0];
        in_use_rm = use_m[1];
        in_use_rs = use_m[2];
        in_rd     = rd;
        in_rd_we  = we;
        in_pc     = pc;
        WEN       = wen;
        WADD      = wadd;
        WDAT      = wdat;
        out_ready = ordy;
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] rn,
                        input logic [3:0] rm, input logic [3:0] rs, input logic [2:0] use_m,
                        input logic [3:0] rd, input logic we, input logic [31:0] pc,
                        input logic wen, input logic [3:0] wadd, input logic [31:0] wdat,
                        input logic ordy, input logic exp_rdy);
        rec_t r;
        logic acc;
        @(negedge clk);
        drive(v, rn, rm, rs, use_m, rd, we, pc, wen, wadd, wdat, ordy);
        #1;
        check_val({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        check_val({tag, ".radd"}, {20'd0, RADD3, RADD2, RADD1}, {20'd0, rs, rm, rn});
        acc = v && exp_rdy;
        if (acc) begin
            r.op1   = exp_op(rn);
            r.op2   = exp_op(rm);
            r.op3   = exp_op(rs);
            r.rd    = rd;
            r.rd_we = we;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        if (acc) exp_valid = 1'b1;
        else if (ordy) exp_valid = 1'b0;
        check_val({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
        if (acc) begin
            if (exp_q.size() == 0) begin
                check_val({tag, ".queue"}, 32'd0, 32'd1);
            end else begin
                last_rec = exp_q.pop_front();
                check_slot(tag, last_rec);
            end
        end else if (exp_valid) begin
            check_slot({tag, ".hold"}, last_rec);
        end
        $display("[TB] %-14s accept=%0b out_valid=%0b op1=%08h op2=%08h op3=%08h rd=%0d we=%0b",
                 tag, acc, out_valid, out_op1, out_op2, out_op3, out_rd, out_rd_we);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'd1 << i;
        exp_valid = 1'b0;
        last_rec  = '{op1: 32'd0, op2: 32'd0, op3: 32'd0, rd: 4'd0, rd_we: 1'b0};
        drive(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check_val("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check_slot("reset", last_rec);
        @(negedge clk);
        rst_n = 1'b1;

        //   tag            v  rn    rm    rs     use     rd    we  pc            wen wadd  wdat          ordy rdy
        step("idle",        0, 4'd9, 4'd10, 4'd11, 3'b000, 4'd0, 0, 32'd0,        0, 4'd0, 32'd0,        1, 1);
        step("t2_basic",    1, 4'd2, 4'd3, 4'd0,  3'b011, 4'd1, 0, 32'd0,        0, 4'd0, 32'd0,        1, 1);
        step("t3_issue",    1, 4'd0, 4'd0, 4'd0,  3'b001, 4'd5, 1, 32'd0,        0, 4'd0, 32'd0,        1, 1);
        step("t3_stall_a",  1, 4'd5, 4'd0, 4'd0,  3'b001, 4'd6, 0, 32'd0,        0, 4'd0, 32'd0,        1, 0);
        step("t3_stall_b",  1, 4'd5, 4'd0, 4'd0,  3'b001, 4'd6, 0, 32'd0,        0, 4'd0, 32'd0,        1, 0);
        step("t3_bypass",   1, 4'd5, 4'd0, 4'd0,  3'b001, 4'd6, 0, 32'd0,        1, 4'd5, 32'hDEAD,     1, 1);
        step("t4_pc",       1, 4'd0, 4'd0, 4'd15, 3'b100, 4'd0, 0, 32'h100,      0, 4'd0, 32'd0,        1, 1);
        step("t4_pc_wrap",  1, 4'd0, 4'd0, 4'd15, 3'b100, 4'd0, 0, 32'hFFFFFFFC, 0, 4'd0, 32'd0,        1, 1);
        for (int i = 0; i < 3; i++)
            step("t5_hold",  1, 4'd1, 4'd2, 4'd3,  3'b111, 4'd3, 1, 32'd0,        0, 4'd0, 32'd0,        0, 0);
        step("t5_release",  1, 4'd1, 4'd2, 4'd3,  3'b111, 4'd3, 1, 32'd0,        0, 4'd0, 32'd0,        1, 1);
        step("unused_src",  1, 4'd0, 4'd3, 4'd0,  3'b001, 4'd0, 0, 32'd0,        0, 4'd0, 32'd0,        1, 1);
        step("t6_set7",     1, 4'd0, 4'd0, 4'd0,  3'b001, 4'd7, 1, 32'd0,        0, 4'd0, 32'd0,        1, 1);
        step("t6_setclr",   1, 4'd0, 4'd0, 4'd0,  3'b001, 4'd7, 1, 32'd0,        1, 4'd7, 32'h77,       1, 1);
        step("t6_stall7",   1, 4'd7, 4'd0, 4'd0,  3'b001, 4'd8, 0, 32'd0,        0, 4'd0, 32'd0,        1, 0);
        step("t6_fill",     1, 4'd0, 4'd0, 4'd0,  3'b001, 4'd9, 1, 32'd0,        0, 4'd0, 32'd0,        1, 1);

        // Asynchronous reset in the middle of a stalled, held cycle.
        @(negedge clk);
        drive(1'b1, 4'd7, 4'd0, 4'd0, 3'b001, 4'd8, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        check_val("t6_prereset.in_ready", {31'd0, in_ready}, 32'd0);
        check_val("t6_prereset.out_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_valid = 1'b0;
        last_rec  = '{op1: 32'd0, op2: 32'd0, op3: 32'd0, rd: 4'd0, rd_we: 1'b0};
        check_val("t6_reset.out_valid", {31'd0, out_valid}, 32'd0);
        check_val("t6_reset.in_ready", {31'd0, in_ready}, 32'd1);
        check_slot("t6_reset", last_rec);
        $display("[TB] t6_reset       out_valid=%0b in_ready=%0b", out_valid, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_after_rst", 1, 4'd7, 4'd0, 4'd0, 3'b001, 4'd8, 0, 32'd0,       0, 4'd0, 32'd0,        1, 1);
        step("t6_idle",      0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 0, 32'd0,       1, 4'd9, 32'd5,        1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
